// File: rtl/score_accumulator.sv
// ============================================================================
// Module   : score_accumulator
// Purpose  : Packed-BCD score accumulator with frame-synchronous publish.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_accumulator #(
  parameter int NUM_DIGITS = 6,
  parameter int MAX_PASSES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    clear_valid,
  output logic                    clear_ready,
  input  logic [2:0]              clear_lines,
  input  logic [3:0]              level,
  input  logic                    score_clear,
  input  logic                    frame_sync,
  output logic [4*NUM_DIGITS-1:0] score_digits,
  output logic                    busy,
  output logic                    overflow
);

  localparam int SCORE_W = 4 * NUM_DIGITS;
  localparam int DIDX_W  = $clog2(NUM_DIGITS);
  localparam int PASS_W  = $clog2(MAX_PASSES);

  localparam logic [DIDX_W-1:0]  LAST_DIGIT = DIDX_W'(NUM_DIGITS - 1);
  localparam logic [SCORE_W-1:0] ALL_NINES  = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   accum_q, accum_d;
  logic [SCORE_W-1:0]   addend_q, addend_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 overflow_q, overflow_d;
  logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [DIDX_W-1:0]    digit_idx_q, digit_idx_d;
  logic                 carry_q, carry_d;

  logic [SCORE_W-1:0]   points;
  logic                 points_valid;
  logic [3:0]           acc_digit;
  logic [3:0]           add_digit;
  logic [4:0]           digit_sum;
  logic [3:0]           new_digit;
  logic                 carry_out;

  always_comb begin
    points       = '0;
    points_valid = 1'b1;
    case (clear_lines)
      3'd1:    points = SCORE_W'(16'h0040);
      3'd2:    points = SCORE_W'(16'h0100);
      3'd3:    points = SCORE_W'(16'h0300);
      3'd4:    points = SCORE_W'(16'h1200);
      default: points_valid = 1'b0;
    endcase
  end

  // Single BCD digit adder shared by every digit position.
  always_comb begin
    acc_digit = 4'd0;
    add_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == DIDX_W'(i)) begin
        acc_digit = accum_q[4*i +: 4];
        add_digit = addend_q[4*i +: 4];
      end
    end
    digit_sum = {1'b0, acc_digit} + {1'b0, add_digit} + {4'b0000, carry_q};
    carry_out = (digit_sum > 5'd9);
    new_digit = carry_out ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
  end

  always_comb begin
    state_d     = state_q;
    accum_d     = accum_q;
    addend_d    = addend_q;
    score_d     = score_q;
    overflow_d  = overflow_q;
    pass_cnt_d  = pass_cnt_q;
    digit_idx_d = digit_idx_q;
    carry_d     = carry_q;

    // Publishes the pre-transfer accum even if an event is accepted this cycle.
    if (frame_sync && (state_q == IDLE)) begin
      score_d = accum_q;
    end

    case (state_q)
      IDLE: begin
        if (clear_valid && points_valid) begin
          addend_d    = points;
          pass_cnt_d  = PASS_W'(level);
          digit_idx_d = '0;
          carry_d     = 1'b0;
          state_d     = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digit_idx_q == DIDX_W'(i)) begin
            accum_d[4*i +: 4] = new_digit;
          end
        end
        carry_d = carry_out;
        if (digit_idx_q == LAST_DIGIT) begin
          if (carry_out) begin
            state_d = SAT;
          end else if (pass_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            pass_cnt_d  = pass_cnt_q - 1'b1;
            digit_idx_d = '0;
            carry_d     = 1'b0;
          end
        end else begin
          digit_idx_d = digit_idx_q + 1'b1;
        end
      end
      SAT: begin
        accum_d    = ALL_NINES;
        overflow_d = 1'b1;
        pass_cnt_d = '0;
        carry_d    = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (score_clear) begin
      accum_d     = '0;
      score_d     = '0;
      overflow_d  = 1'b0;
      pass_cnt_d  = '0;
      digit_idx_d = '0;
      carry_d     = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      accum_q     <= '0;
      addend_q    <= '0;
      score_q     <= '0;
      overflow_q  <= 1'b0;
      pass_cnt_q  <= '0;
      digit_idx_q <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      accum_q     <= accum_d;
      addend_q    <= addend_d;
      score_q     <= score_d;
      overflow_q  <= overflow_d;
      pass_cnt_q  <= pass_cnt_d;
      digit_idx_q <= digit_idx_d;
      carry_q     <= carry_d;
    end
  end

  assign clear_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign score_digits = score_q;
  assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_score_accumulator.sv
// ============================================================================
// Module   : tb_score_accumulator
// Purpose  : Directed bench for score_accumulator with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_valid;
  logic        clear_ready;
  logic [2:0]  clear_lines;
  logic [3:0]  level;
  logic        score_clear;
  logic        frame_sync;
  logic [23:0] score_digits;
  logic        busy;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;
  int cycles;

  always #5 clk = ~clk;

  score_accumulator #(.NUM_DIGITS(6), .MAX_PASSES(16)) u_dut (
    .Clk          (clk),
    .Reset        (rst),
    .clear_valid  (clear_valid),
    .clear_ready  (clear_ready),
    .clear_lines  (clear_lines),
    .level        (level),
    .score_clear  (score_clear),
    .frame_sync   (frame_sync),
    .score_digits (score_digits),
    .busy         (busy),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_event(input logic [2:0] lines, input logic [3:0] lvl);
    clear_valid = 1'b1;
    clear_lines = lines;
    level       = lvl;
    step();
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    level       = 4'd0;
  endtask

  task automatic pulse_frame();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      step();
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    level       = 4'd0;
    score_clear = 1'b0;
    frame_sync  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_score", {8'd0, score_digits}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ready", {31'd0, clear_ready}, 32'd1);

    // 1 line, level 0
    send_event(3'd1, 4'd0);
    check("ev1_ready_low", {31'd0, clear_ready}, 32'd0);
    wait_idle(cycles);
    check("ev1_busy_cycles", cycles, 32'd6);
    pulse_frame();
    check("ev1_score", {8'd0, score_digits}, 32'h000040);

    // 4 lines, level 2: 3 x 1200
    send_event(3'd4, 4'd2);
    wait_idle(cycles);
    check("ev2_busy_cycles", cycles, 32'd18);
    pulse_frame();
    check("ev2_score", {8'd0, score_digits}, 32'h003640);

    // frame_sync while busy must not publish
    send_event(3'd2, 4'd0);
    pulse_frame();
    check("busy_frame_hold", {8'd0, score_digits}, 32'h003640);
    wait_idle(cycles);
    check("busy_frame_rest", cycles, 32'd5);
    pulse_frame();
    check("after_busy_pub", {8'd0, score_digits}, 32'h003740);

    // transfer and frame_sync in the same IDLE cycle: old accum published
    frame_sync = 1'b1;
    send_event(3'd1, 4'd0);
    frame_sync = 1'b0;
    check("same_cycle_pub", {8'd0, score_digits}, 32'h003740);
    wait_idle(cycles);
    pulse_frame();
    check("same_cycle_next", {8'd0, score_digits}, 32'h003780);

    // illegal line counts are swallowed
    clear_valid = 1'b1;
    clear_lines = 3'd0;
    #1;
    check("lines0_ready", {31'd0, clear_ready}, 32'd1);
    step();
    check("lines0_busy", {31'd0, busy}, 32'd0);
    clear_lines = 3'd5;
    step();
    check("lines5_busy", {31'd0, busy}, 32'd0);
    check("lines5_ready", {31'd0, clear_ready}, 32'd1);
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    pulse_frame();
    check("illegal_score", {8'd0, score_digits}, 32'h003780);

    // score_clear mid-ADD together with an offered event
    send_event(3'd4, 4'd3);
    step();
    check("mid_add_busy", {31'd0, busy}, 32'd1);
    score_clear = 1'b1;
    clear_valid = 1'b1;
    clear_lines = 3'd1;
    step();
    score_clear = 1'b0;
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    check("clr_score", {8'd0, score_digits}, 32'h0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_ready", {31'd0, clear_ready}, 32'd1);
    step();
    check("clr_no_accept", {31'd0, busy}, 32'd0);
    pulse_frame();
    check("clr_accum", {8'd0, score_digits}, 32'h0);

    // load to 999960: 52 x 19200 + 1200 + 2 x 100 + 4 x 40
    for (int i = 0; i < 52; i++) begin
      send_event(3'd4, 4'd15);
      wait_idle(cycles);
    end
    send_event(3'd4, 4'd0);
    wait_idle(cycles);
    send_event(3'd2, 4'd1);
    wait_idle(cycles);
    send_event(3'd1, 4'd3);
    wait_idle(cycles);
    pulse_frame();
    check("load_score", {8'd0, score_digits}, 32'h999960);
    check("load_ovf", {31'd0, overflow}, 32'd0);

    // +40 carries out of digit 5 -> saturate
    send_event(3'd1, 4'd0);
    wait_idle(cycles);
    check("sat_busy_cycles", cycles, 32'd7);
    check("sat_ovf", {31'd0, overflow}, 32'd1);
    pulse_frame();
    check("sat_score", {8'd0, score_digits}, 32'h999999);

    send_event(3'd3, 4'd1);
    wait_idle(cycles);
    pulse_frame();
    check("sat_hold_score", {8'd0, score_digits}, 32'h999999);
    check("sat_hold_ovf", {31'd0, overflow}, 32'd1);

    // new game clears overflow
    score_clear = 1'b1;
    step();
    score_clear = 1'b0;
    check("newgame_ovf", {31'd0, overflow}, 32'd0);
    check("newgame_score", {8'd0, score_digits}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
- Sequences the 6-digit packed-BCD score that drives the score-digit font lookup in the colour mapper (digit 5 = bits [23:20], leftmost on screen).
- Accepts line-clear events from game logic and converts lines-cleared and level into a points value.
- Adds the points into a working BCD accumulator, one digit per cycle.
- Publishes the accumulator to the display register only on a frame-sync pulse, so the score never changes mid-frame.

Parameters:
- NUM_DIGITS, 6, BCD digits in accumulator/display (score_digits width = 4*NUM_DIGITS).
- MAX_PASSES, 16, maximum add passes per event (level+1, level is 4 bits).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- clear_valid  in  1  line-clear event offered.
- clear_ready  out  1  block can accept an event this cycle.
- clear_lines  in  3  lines cleared by the event (valid codes 1..4).
- level  in  4  current level, sampled on acceptance.
- score_clear  in  1  new-game pulse; zeroes all score state.
- frame_sync  in  1  single-cycle pulse at start of vertical blank.
- score_digits  out  24  published packed-BCD score.
- busy  out  1  add sequence in progress.
- overflow  out  1  sticky; score saturated at 999999.

Behaviour:
- Reset values: all outputs and internal state are zero; FSM is in IDLE; clear_ready=1 after the reset cycle.
- Reset and score_clear are synchronous. Either one forces the following on the next edge, from any state, aborting any sequence in progress:
  - accum=0, score_digits=0, overflow=0, FSM=IDLE.
  - score_clear takes priority over clear_valid and frame_sync in the same cycle.
- Handshake:
  - clear_ready = (state==IDLE).
  - An event transfers on clear_valid & clear_ready.
  - clear_lines and level are captured at transfer and ignored afterwards.
- Points table (BCD), loaded into the addend register at transfer:
  - 1 line → 000040
  - 2 lines → 000100
  - 3 lines → 000300
  - 4 lines → 001200
  - 0 or 5..7 lines → event accepted, no state change; FSM stays in IDLE.
- FSM:
  - IDLE: on a valid transfer (1..4 lines), load the addend, set pass_cnt=level, digit_idx=0, carry=0, and go to ADD. busy=0 in IDLE.
  - ADD, one digit per cycle:
    - s = accum[digit_idx] + addend[digit_idx] + carry.
    - If s>9, the digit becomes s-10 and carry=1; otherwise the digit is s and carry=0.
    - The 5-bit intermediate sum must not truncate.
    - digit_idx increments 0..5.
    - After digit 5 with carry=1: go to SAT.
    - After digit 5 with carry=0 and pass_cnt==0: go to IDLE.
    - After digit 5 with carry=0 and pass_cnt!=0: decrement pass_cnt, set digit_idx=0, carry=0, and stay in ADD.
  - SAT: set accum=999999 and overflow=1, drop remaining passes, go to IDLE (1 cycle).
  - busy=1 in ADD and SAT.
- Latency: accept → IDLE takes 6*(level+1) cycles (+1 cycle if saturating). Worst case is 96 cycles, well under one frame.
- Saturated state: once overflow=1, further events are still accepted and handshaken but leave accum at 999999.
- Publish rule:
  - On frame_sync while state==IDLE: score_digits <= accum. A transfer in the same cycle does not affect the published value (old accum is published).
  - On frame_sync while busy: no publish, no pending flag; the next frame_sync publishes.
- Intermediate digit values are never visible on score_digits.
- Illegal BCD cannot arise internally; inputs are not BCD-checked.

Test Plan:
- Reset, then 1-line event at level 0, then frame_sync → busy high for exactly 6 cycles; score_digits=24'h000040.
- 4 lines at level 2 from score 000040, frame_sync after IDLE → 18 busy cycles; score_digits=24'h003640.
- Load to 999960 via events, then 1 line at level 0 → SAT entered; overflow=1; published 24'h999999; a subsequent event keeps 999999.
- frame_sync pulsed during ADD → score_digits unchanged; next frame_sync in IDLE publishes the new sum.
- score_clear asserted mid-ADD together with clear_valid → next cycle accum=0, score_digits=0, overflow=0, IDLE; the event is not accepted.
- clear_lines=0 and clear_lines=5 with clear_valid → clear_ready stays 1; busy never asserts; score unchanged.
